mem_arbiter: RTL and testbench

- Parametrised successor to the fixed direct core-to-memory wiring in the system top.
- Arbitrates NUM_PORTS requesters onto one single-ported memory with a fixed read latency:
  - port 0 = instruction fetch;
  - port 1 = data access;
  - further ports = DMA/debug.
- Round-robin grant, one outstanding transaction, valid/ready request handshake, single-cycle response pulse, misalignment error reporting.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-ported, fixed-latency memory among
// NUM_PORTS requesters, with one transaction in flight at a time.
module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS-1:0]            req_wen,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_wstrb,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic                            resp_err,
    output logic [DATA_W-1:0]               resp_rdata,
    output logic                            mem_en,
    output logic                            mem_wen,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic [DATA_W/8-1:0]             mem_wstrb,
    input  logic [DATA_W-1:0]               mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(NUM_PORTS);
    localparam int CNT_W  = $clog2(MEM_LAT + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_next;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand;
    logic                grant_found;
    logic                accept;
    logic                sel_misaligned;
    logic [ADDR_W-1:0]   sel_addr;
    logic [CNT_W-1:0]    lat_cnt;
    logic                txn_wen;
    logic                txn_err;
    logic [DATA_W-1:0]   rdata_q;

    // Search starts just after the last winner so every port gets its turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept         = (state == IDLE) && grant_found;
    assign sel_addr       = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_misaligned = |(sel_addr & ALIGN_MASK);

    // Gated by rst_n so no requester sees a handshake while reset is held.
    assign req_ready  = (accept && rst_n) ? (NUM_PORTS'(1) << grant_idx) : '0;
    assign resp_valid = (state == RESP) ? (NUM_PORTS'(1) << rr_ptr) : '0;
    assign resp_err   = (state == RESP) && txn_err;
    assign resp_rdata = (state == RESP && !txn_wen && !txn_err) ? rdata_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = sel_misaligned ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (lat_cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A misaligned request never reaches the memory pins; it only records the error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= PTR_W'(NUM_PORTS - 1);
            txn_wen   <= 1'b0;
            txn_err   <= 1'b0;
            lat_cnt   <= '0;
            rdata_q   <= '0;
            mem_en    <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr  <= grant_idx;
                        txn_wen <= req_wen[grant_idx];
                        txn_err <= sel_misaligned;
                        if (!sel_misaligned) begin
                            mem_en    <= 1'b1;
                            mem_wen   <= req_wen[grant_idx];
                            mem_addr  <= sel_addr;
                            mem_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
                            mem_wstrb <= req_wstrb[grant_idx*STRB_W +: STRB_W];
                        end
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_wen <= 1'b0;
                    lat_cnt <= CNT_W'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        rdata_q <= mem_rdata;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-port/latency-1 instance driven from a vector table
// and directed sequences, and a 3-port/latency-3 instance under random traffic.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NA = 2;
    localparam int LA = 1;
    localparam int NB = 3;
    localparam int LB = 3;
    localparam int NVEC = 14;

    typedef struct {
        int          port;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        mem;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a;
    logic rst_n_b;
    int   errors;
    int   checks;

    logic [NA-1:0]    a_req_valid, a_req_ready, a_req_wen, a_resp_valid;
    logic [NA*AW-1:0] a_req_addr;
    logic [NA*DW-1:0] a_req_wdata;
    logic [NA*SW-1:0] a_req_wstrb;
    logic             a_resp_err, a_mem_en, a_mem_wen;
    logic [DW-1:0]    a_resp_rdata, a_mem_wdata, a_mem_rdata;
    logic [AW-1:0]    a_mem_addr;
    logic [SW-1:0]    a_mem_wstrb;

    logic [NB-1:0]    b_req_valid, b_req_ready, b_req_wen, b_resp_valid;
    logic [NB*AW-1:0] b_req_addr;
    logic [NB*DW-1:0] b_req_wdata;
    logic [NB*SW-1:0] b_req_wstrb;
    logic             b_resp_err, b_mem_en, b_mem_wen;
    logic [DW-1:0]    b_resp_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0]    b_mem_addr;
    logic [SW-1:0]    b_mem_wstrb;

    mem_arbiter #(.NUM_PORTS(NA), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LA)) dut_a (
        .clk(clk), .rst_n(rst_n_a),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .req_wen(a_req_wen), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .resp_valid(a_resp_valid), .resp_err(a_resp_err), .resp_rdata(a_resp_rdata),
        .mem_en(a_mem_en), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.NUM_PORTS(NB), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LB)) dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_wen(b_req_wen), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .resp_valid(b_resp_valid), .resp_err(b_resp_err), .resp_rdata(b_resp_rdata),
        .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata)
    );

    // Memory responders: read data appears exactly MEM_LAT cycles after mem_en, junk otherwise.
    logic [31:0] mem_a  [0:255];
    logic [31:0] mem_b  [0:255];
    logic [31:0] ref_b  [0:255];
    logic [31:0] pipe_a [0:LA];
    logic [31:0] pipe_b [0:LB];

    always @(negedge clk) begin
        for (int i = LA; i > 0; i--) pipe_a[i] = pipe_a[i-1];
        pipe_a[0] = $urandom;
        if (a_mem_en) begin
            if (a_mem_wen) begin
                for (int b = 0; b < SW; b++)
                    if (a_mem_wstrb[b]) mem_a[a_mem_addr[9:2]][b*8 +: 8] = a_mem_wdata[b*8 +: 8];
            end else begin
                pipe_a[0] = mem_a[a_mem_addr[9:2]];
            end
        end
        a_mem_rdata = pipe_a[LA];
    end

    always @(negedge clk) begin
        for (int i = LB; i > 0; i--) pipe_b[i] = pipe_b[i-1];
        pipe_b[0] = $urandom;
        if (b_mem_en) begin
            if (b_mem_wen) begin
                for (int b = 0; b < SW; b++)
                    if (b_mem_wstrb[b]) mem_b[b_mem_addr[9:2]][b*8 +: 8] = b_mem_wdata[b*8 +: 8];
            end else begin
                pipe_b[0] = mem_b[b_mem_addr[9:2]];
            end
        end
        b_mem_rdata = pipe_b[LB];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [NA-1:0] ohA(input int p);
        logic [NA-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [NB-1:0] ohB(input int p);
        logic [NB-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // One lone request on dut_a, followed cycle by cycle until its response.
    task automatic applyStimulus(input vec_t v, input int idx);
        a_req_valid = '0;
        a_req_valid[v.port] = 1'b1;
        a_req_wen[v.port] = v.wen;
        a_req_addr[v.port*AW +: AW] = v.addr;
        a_req_wdata[v.port*DW +: DW] = v.wdata;
        a_req_wstrb[v.port*SW +: SW] = v.wstrb;
        @(negedge clk);
        checkOutput($sformatf("v%0d_ready", idx), a_req_ready, ohA(v.port));
        @(posedge clk);
        #1;
        a_req_valid = '0;
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput($sformatf("v%0d_mem_en", idx), a_mem_en, v.mem);
                if (v.mem) begin
                    checkOutput($sformatf("v%0d_mem_addr", idx), a_mem_addr, v.addr);
                    checkOutput($sformatf("v%0d_mem_wen", idx), a_mem_wen, v.wen);
                    if (v.wen) begin
                        checkOutput($sformatf("v%0d_mem_wdata", idx), a_mem_wdata, v.wdata);
                        checkOutput($sformatf("v%0d_mem_wstrb", idx), a_mem_wstrb, v.wstrb);
                    end
                end
            end else begin
                checkOutput($sformatf("v%0d_mem_en_k%0d", idx, k), a_mem_en, 1'b0);
                checkOutput($sformatf("v%0d_mem_wen_k%0d", idx, k), a_mem_wen, 1'b0);
            end
            checkOutput($sformatf("v%0d_resp_valid_k%0d", idx, k), a_resp_valid,
                        (k == v.lat) ? ohA(v.port) : '0);
            if (k == v.lat) begin
                checkOutput($sformatf("v%0d_resp_err", idx), a_resp_err, v.err);
                checkOutput($sformatf("v%0d_resp_rdata", idx), a_resp_rdata, v.rdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs [NVEC];
    int          rr_m, next_free, resp_cyc, mem_cyc, resp_port, g;
    logic        e_err, e_wen;
    logic [31:0] e_data, e_addr, e_wdata, cur_addr;
    logic [3:0]  e_wstrb;
    logic [NB-1:0] pend;
    int          port_exp;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'hA500_0000 | i;
            mem_b[i] = 32'hB500_0000 | i;
            ref_b[i] = 32'hB500_0000 | i;
        end
        mem_a[4] = 32'hDEAD_BEEF;
        for (int i = 0; i <= LA; i++) pipe_a[i] = '0;
        for (int i = 0; i <= LB; i++) pipe_b[i] = '0;

        vecs[0]  = '{0, 1'b0, 32'h10,  32'h0,         4'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b1};
        vecs[1]  = '{1, 1'b1, 32'h20,  32'h1234_5678, 4'h3, 3, 1'b0, 32'h0,         1'b1};
        vecs[2]  = '{1, 1'b0, 32'h20,  32'h0,         4'h0, 3, 1'b0, 32'hA500_5678, 1'b1};
        vecs[3]  = '{1, 1'b0, 32'h22,  32'h0,         4'h0, 1, 1'b1, 32'h0,         1'b0};
        vecs[4]  = '{0, 1'b1, 32'h30,  32'hFFFF_FFFF, 4'h0, 3, 1'b0, 32'h0,         1'b1};
        vecs[5]  = '{0, 1'b0, 32'h30,  32'h0,         4'h0, 3, 1'b0, 32'hA500_000C, 1'b1};
        vecs[6]  = '{0, 1'b1, 32'h31,  32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'h0,         1'b0};
        vecs[7]  = '{0, 1'b0, 32'h30,  32'h0,         4'h0, 3, 1'b0, 32'hA500_000C, 1'b1};
        vecs[8]  = '{1, 1'b1, 32'h3C,  32'hCAFE_F00D, 4'hF, 3, 1'b0, 32'h0,         1'b1};
        vecs[9]  = '{0, 1'b0, 32'h3C,  32'h0,         4'h0, 3, 1'b0, 32'hCAFE_F00D, 1'b1};
        vecs[10] = '{1, 1'b1, 32'h40,  32'h1122_3344, 4'hC, 3, 1'b0, 32'h0,         1'b1};
        vecs[11] = '{1, 1'b0, 32'h40,  32'h0,         4'h0, 3, 1'b0, 32'h1122_0010, 1'b1};
        vecs[12] = '{1, 1'b0, 32'h3FC, 32'h0,         4'h0, 3, 1'b0, 32'hA500_00FF, 1'b1};
        vecs[13] = '{0, 1'b0, 32'h1,   32'h0,         4'h0, 1, 1'b1, 32'h0,         1'b0};

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        a_req_valid = 2'b11;
        a_req_wen = '0;
        a_req_addr = {32'h100, 32'h10};
        a_req_wdata = '0;
        a_req_wstrb = '0;
        b_req_valid = 3'b111;
        b_req_wen = '0;
        b_req_addr = '0;
        b_req_wdata = '0;
        b_req_wstrb = '0;
        repeat (2) @(negedge clk);

        checkOutput("rst_req_ready", a_req_ready, '0);
        checkOutput("rst_resp_valid", a_resp_valid, '0);
        checkOutput("rst_resp_err", a_resp_err, 1'b0);
        checkOutput("rst_resp_rdata", a_resp_rdata, '0);
        checkOutput("rst_mem_en", a_mem_en, 1'b0);
        checkOutput("rst_mem_wen", a_mem_wen, 1'b0);
        checkOutput("rst_mem_addr", a_mem_addr, '0);
        checkOutput("rst_mem_wdata", a_mem_wdata, '0);
        checkOutput("rst_mem_wstrb", a_mem_wstrb, '0);
        checkOutput("rst_b_req_ready", b_req_ready, '0);
        checkOutput("rst_b_mem_en", b_mem_en, 1'b0);

        b_req_valid = '0;
        @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Two permanent requesters: accepts every 4 cycles, alternating from port 0.
        a_req_valid = 2'b11;
        a_req_addr = {32'h100, 32'h0};
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            port_exp = (c / 4) % 2;
            checkOutput($sformatf("rr_ready_c%0d", c), a_req_ready, (c % 4 == 0) ? ohA(port_exp) : '0);
            checkOutput($sformatf("rr_mem_en_c%0d", c), a_mem_en, (c % 4 == 1));
            checkOutput($sformatf("rr_resp_c%0d", c), a_resp_valid, (c % 4 == 3) ? ohA(port_exp) : '0);
            if (c % 4 == 3)
                checkOutput($sformatf("rr_rdata_c%0d", c), a_resp_rdata,
                            port_exp == 1 ? 32'hA500_0040 : 32'hA500_0000);
        end
        @(posedge clk);
        #1;
        a_req_valid = '0;

        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

        // Reset while a read is in WAIT: nothing may survive it.
        a_req_valid = 2'b10;
        a_req_addr = {32'h20, 32'h10};
        a_req_wen = '0;
        @(negedge clk);
        checkOutput("mr_ready_p1", a_req_ready, 2'b10);
        @(posedge clk);
        #1;
        a_req_valid = '0;
        @(posedge clk);
        #1;
        a_req_valid = 2'b11;
        rst_n_a = 1'b0;
        #1;
        checkOutput("mr_mem_en", a_mem_en, 1'b0);
        checkOutput("mr_resp_valid", a_resp_valid, '0);
        checkOutput("mr_req_ready", a_req_ready, '0);
        @(negedge clk);
        checkOutput("mr_resp_valid_late", a_resp_valid, '0);
        @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        @(negedge clk);
        checkOutput("mr_first_grant", a_req_ready, 2'b01);
        @(posedge clk);
        #1;
        a_req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("mr_resp_k%0d", k), a_resp_valid, (k == 3) ? 2'b01 : 2'b00);
            if (k == 1) checkOutput("mr_mem_addr", a_mem_addr, 32'h10);
            if (k == 3) checkOutput("mr_rdata", a_resp_rdata, 32'hDEAD_BEEF);
        end
        @(posedge clk);
        #1;

        // Latency-3 instance, ports 0 and 2 requesting: accepts 6 cycles apart.
        b_req_valid = 3'b101;
        b_req_addr = {32'h50, 32'h0, 32'h8};
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            port_exp = ((c / 6) % 2 == 1) ? 2 : 0;
            checkOutput($sformatf("l3_ready_c%0d", c), b_req_ready, (c % 6 == 0) ? ohB(port_exp) : '0);
            checkOutput($sformatf("l3_mem_en_c%0d", c), b_mem_en, (c % 6 == 1));
            checkOutput($sformatf("l3_resp_c%0d", c), b_resp_valid, (c % 6 == 5) ? ohB(port_exp) : '0);
            if (c % 6 == 5)
                checkOutput($sformatf("l3_rdata_c%0d", c), b_resp_rdata,
                            port_exp == 2 ? 32'hB500_0014 : 32'hB500_0002);
        end
        @(posedge clk);
        #1;
        b_req_valid = '0;

        // Random traffic against a cycle-count model of accepts, strobes and responses.
        rr_m = 2;
        next_free = 0;
        resp_cyc = -1;
        mem_cyc = -1;
        resp_port = 0;
        pend = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < NB; p++) begin
                if (pend[p] && $urandom_range(0, 15) == 0) begin
                    pend[p] = 1'b0;
                end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    b_req_wen[p] = $urandom_range(0, 1) == 1;
                    cur_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                    if ($urandom_range(0, 3) == 0) cur_addr[1:0] = 2'($urandom_range(1, 3));
                    b_req_addr[p*AW +: AW] = cur_addr;
                    b_req_wdata[p*DW +: DW] = $urandom;
                    b_req_wstrb[p*SW +: SW] = 4'($urandom_range(0, 15));
                end
                b_req_valid[p] = pend[p];
            end
            @(negedge clk);
            g = -1;
            if (cyc >= next_free)
                for (int k = 1; k <= NB; k++)
                    if (g < 0 && b_req_valid[(rr_m + k) % NB]) g = (rr_m + k) % NB;
            checkOutput("rnd_ready", b_req_ready, (g >= 0) ? ohB(g) : '0);
            checkOutput("rnd_resp_valid", b_resp_valid, (cyc == resp_cyc) ? ohB(resp_port) : '0);
            if (cyc == resp_cyc) begin
                checkOutput("rnd_resp_err", b_resp_err, e_err);
                checkOutput("rnd_resp_rdata", b_resp_rdata, e_data);
            end
            checkOutput("rnd_mem_en", b_mem_en, cyc == mem_cyc);
            if (cyc == mem_cyc) begin
                checkOutput("rnd_mem_addr", b_mem_addr, e_addr);
                checkOutput("rnd_mem_wen", b_mem_wen, e_wen);
                if (e_wen) begin
                    checkOutput("rnd_mem_wdata", b_mem_wdata, e_wdata);
                    checkOutput("rnd_mem_wstrb", b_mem_wstrb, e_wstrb);
                end
            end
            if (g >= 0) begin
                rr_m = g;
                pend[g] = 1'b0;
                resp_port = g;
                e_addr = b_req_addr[g*AW +: AW];
                e_wen = b_req_wen[g];
                e_wdata = b_req_wdata[g*DW +: DW];
                e_wstrb = b_req_wstrb[g*SW +: SW];
                if (e_addr[1:0] != 2'b00) begin
                    e_err = 1'b1;
                    e_data = '0;
                    resp_cyc = cyc + 1;
                    next_free = cyc + 2;
                end else begin
                    e_err = 1'b0;
                    mem_cyc = cyc + 1;
                    resp_cyc = cyc + 2 + LB;
                    next_free = cyc + 3 + LB;
                    if (e_wen) begin
                        e_data = '0;
                        for (int b = 0; b < SW; b++)
                            if (e_wstrb[b]) ref_b[e_addr[9:2]][b*8 +: 8] = e_wdata[b*8 +: 8];
                    end else begin
                        e_data = ref_b[e_addr[9:2]];
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
